serial_rx_controller: RTL and testbench

Sequencing controller for the serial character-receive path. It detects the start bit on the incoming `bitStream`, drives `enable` and the shift strobe `SRclk`, and runs the bit-sample counter (BSC) and bit-identification counter (BIC). It assembles each character into a holding register and hands it to the processor through a ready/acknowledge handshake, flagging framing and overrun errors. It sits between the serial line and the microprocessor's I/O bus and replaces ad-hoc enable generation for the character-bit-count datapath.

---
 rtl/serial_rx_controller_if.sv | 23 ++
 rtl/serial_rx_controller.sv | 117 +++++++++++
 tb/tb_serial_rx_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_rx_controller_if.sv
// serial_rx_controller_if: serial line, processor handshake and sequencing outputs of the receive controller
interface serial_rx_controller_if #(
    parameter int DATA_BITS = 8
);
    logic                 bitStream;
    logic                 readAck;
    logic                 enable;
    logic                 SRclk;
    logic [3:0]           BSC;
    logic [3:0]           BIC;
    logic [DATA_BITS-1:0] rxData;
    logic                 dataReady;
    logic                 framingErr;
    logic                 overrun;
    modport master (
        input  bitStream, readAck,
        output enable, SRclk, BSC, BIC, rxData, dataReady, framingErr, overrun
    );
    modport slave (
        output bitStream, readAck,
        input  enable, SRclk, BSC, BIC, rxData, dataReady, framingErr, overrun
    );
endinterface

// File: rtl/serial_rx_controller.sv
// serial_rx_controller: start-bit detection, bit-sample/bit-index sequencing and
// ready/acknowledge handoff of received characters with framing/overrun flags
module serial_rx_controller #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 7
) (
    input logic clk,
    input logic reset,
    serial_rx_controller_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam logic [3:0] SAMPLE   = 4'(SAMPLE_POINT);
    localparam logic [3:0] LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] BIC_LAST = 4'(DATA_BITS - 1);
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           state_q, state_d;
    logic [3:0]           bsc_q, bsc_d;
    logic [3:0]           bic_q, bic_d;
    logic                 en_q, en_d;
    logic                 srclk_q, srclk_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic                 rdy_q, rdy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 line, at_sample, at_last, stop_hit, load;
    assign line      = sync_q[1];
    assign at_sample = bsc_q == SAMPLE;
    assign at_last   = bsc_q == LAST;
    assign stop_hit  = state_q == STOP && at_sample;
    // A load always wins over a same-cycle acknowledge, so ack never causes overrun
    assign load      = stop_hit && line && (!rdy_q || bus.readAck);
    always_comb begin
        sync_d  = {sync_q[0], bus.bitStream};
        state_d = state_q;
        bsc_d   = bsc_q + 4'd1;
        bic_d   = bic_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                bsc_d   = 4'd0;
                bic_d   = 4'd0;
                state_d = line ? IDLE : START;
            end
            START: begin
                if (at_sample && line) begin
                    state_d = IDLE;
                    bsc_d   = 4'd0;
                end else if (at_last) begin
                    state_d = DATA;
                    bsc_d   = 4'd0;
                    bic_d   = 4'd0;
                end
            end
            DATA: begin
                shift_d = at_sample ? {line, shift_q[DATA_BITS-1:1]} : shift_q;
                if (at_last) begin
                    bsc_d   = 4'd0;
                    state_d = (bic_q == BIC_LAST) ? STOP : DATA;
                    bic_d   = (bic_q == BIC_LAST) ? bic_q : bic_q + 4'd1;
                end
            end
            default: begin
                if (at_sample) begin
                    state_d = IDLE;
                    bsc_d   = 4'd0;
                    bic_d   = 4'd0;
                end
            end
        endcase
        en_d    = state_d != IDLE;
        srclk_d = state_q == DATA && at_sample;
        rx_d    = load ? shift_q : rx_q;
        rdy_d   = load || (rdy_q && !bus.readAck);
        ovr_d   = (stop_hit && line && rdy_q && !bus.readAck) || (ovr_q && !bus.readAck);
        ferr_d  = (stop_hit && !line) || (ferr_q && !bus.readAck);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            bsc_q   <= 4'd0;
            bic_q   <= 4'd0;
            en_q    <= 1'b0;
            srclk_q <= 1'b0;
            shift_q <= '0;
            rx_q    <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            bsc_q   <= bsc_d;
            bic_q   <= bic_d;
            en_q    <= en_d;
            srclk_q <= srclk_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign bus.enable     = en_q;
    assign bus.SRclk      = srclk_q;
    assign bus.BSC        = bsc_q;
    assign bus.BIC        = bic_q;
    assign bus.rxData     = rx_q;
    assign bus.dataReady  = rdy_q;
    assign bus.framingErr = ferr_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_serial_rx_controller.sv
// tb_serial_rx_controller: directed frames with a scoreboard checked at every end of frame (enable falling)
module tb_serial_rx_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    serial_rx_controller_if #(.DATA_BITS(8)) bus();
    serial_rx_controller dut (.clk(clk), .reset(reset), .bus(bus.master));
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] rx;
        logic       rdy;
        logic       ferr;
        logic       ovr;
        int         nsr;
        int         len;
    } exp_t;
    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   len = 0;
    int   nsr = 0;
    logic prev_en = 1'b0;
    exp_t e;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic push(input logic [7:0] rx, input logic rdy, input logic ferr, input logic ovr,
                        input int n, input int l);
        exp_t x;
        x.rx = rx; x.rdy = rdy; x.ferr = ferr; x.ovr = ovr; x.nsr = n; x.len = l;
        q.push_back(x);
    endtask
    task automatic check_zero(input string nm);
        check({nm, "_enable"}, bus.enable, 0);
        check({nm, "_srclk"}, bus.SRclk, 0);
        check({nm, "_bsc"}, bus.BSC, 0);
        check({nm, "_bic"}, bus.BIC, 0);
        check({nm, "_rxdata"}, bus.rxData, 0);
        check({nm, "_ready"}, bus.dataReady, 0);
        check({nm, "_ferr"}, bus.framingErr, 0);
        check({nm, "_ovr"}, bus.overrun, 0);
    endtask
    // One frame = start, 8 data bits LSB first, stop; each bit held 16 clocks.
    // Iteration i drives the value seen by edge e_i; ack_i/rst_i select an edge for readAck/reset.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_i, input int rst_i);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            bus.bitStream = f[i/16];
            bus.readAck = (i == ack_i);
            if (i == rst_i) begin
                check("bic_before_reset", bus.BIC, 4);
                reset = 1'b0;
                #1;
                check_zero("midframe_reset");
                repeat (2) @(negedge clk);
                bus.bitStream = 1'b1;
                bus.readAck = 1'b0;
                reset = 1'b1;
                return;
            end
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.bitStream = 1'b1;
            bus.readAck = 1'b0;
        end
    endtask
    task automatic ack_pulse();
        @(negedge clk);
        bus.readAck = 1'b1;
        @(negedge clk);
        bus.readAck = 1'b0;
        #1;
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            prev_en = 1'b0;
            len = 0;
            nsr = 0;
        end else begin
            if (prev_en && !bus.enable) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame_end: got end of frame expected none");
                end else begin
                    e = q.pop_front();
                    check("sb_rxdata", bus.rxData, e.rx);
                    check("sb_ready", bus.dataReady, e.rdy);
                    check("sb_ferr", bus.framingErr, e.ferr);
                    check("sb_ovr", bus.overrun, e.ovr);
                    check("sb_srclk_count", nsr, e.nsr);
                    check("sb_enable_len", len, e.len);
                end
                len = 0;
                nsr = 0;
            end
            if (bus.enable) len++;
            if (bus.SRclk) nsr++;
            prev_en = bus.enable;
        end
    end
    initial begin
        bus.bitStream = 1'b1;
        bus.readAck = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        idle(5);
        // 0xA5: ready at e154, i.e. enable high 152 cycles
        push(8'hA5, 1, 0, 0, 8, 152);
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(20);
        ack_pulse();
        check("a5_ack_clears_ready", bus.dataReady, 0);
        check("a5_rx_kept", bus.rxData, 8'hA5);
        // 4-cycle glitch: false start after 8 cycles of enable
        push(8'hA5, 0, 0, 0, 0, 8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.bitStream = 1'b0;
        end
        idle(30);
        // Low stop bit: framing error, then the still-low line gives a false start
        push(8'hA5, 0, 1, 0, 8, 152);
        push(8'hA5, 0, 1, 0, 0, 8);
        send_frame(8'h3C, 1'b0, -1, -1);
        idle(30);
        ack_pulse();
        check("ferr_cleared", bus.framingErr, 0);
        check("ferr_rx_kept", bus.rxData, 8'hA5);
        // Back-to-back without ack: overrun, first character kept
        push(8'h11, 1, 0, 0, 8, 152);
        push(8'h11, 1, 0, 1, 8, 152);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(20);
        ack_pulse();
        check("ovr_ack_ready", bus.dataReady, 0);
        check("ovr_ack_ovr", bus.overrun, 0);
        check("ovr_rx", bus.rxData, 8'h11);
        // Ack coincident with the second load at e154: load wins
        push(8'h11, 1, 0, 0, 8, 152);
        push(8'h22, 1, 0, 0, 8, 152);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, 154, -1);
        idle(20);
        ack_pulse();
        check("coinc_ack_ready", bus.dataReady, 0);
        check("coinc_rx", bus.rxData, 8'h22);
        // Reset at BIC==4 (after e82), then a clean frame
        send_frame(8'hFF, 1'b1, -1, 90);
        idle(10);
        push(8'h5A, 1, 0, 0, 8, 152);
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(20);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
